// File: rtl/instr_encoder.sv
// Two-stage instruction encoder: S1 registers the request, S2 holds the encoded
// word with its range-error flag and the word address assigned at delivery.
module instr_encoder (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [2:0]  imm_sel,
   input  logic [6:0]  opcode,
   input  logic [4:0]  rd,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [2:0]  funct3,
   input  logic [6:0]  funct7,
   input  logic [31:0] imm,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] instr,
   output logic [31:0] out_addr,
   output logic        out_err,
   output logic [7:0]  err_cnt,
   input  logic        addr_load,
   input  logic [31:0] addr_base
);

   localparam int unsigned XLEN = 32;
   localparam int unsigned CNTW = 8;

   localparam logic [2:0] SEL_R   = 3'b000;
   localparam logic [2:0] SEL_I   = 3'b001;
   localparam logic [2:0] SEL_B   = 3'b010;
   localparam logic [2:0] SEL_J1  = 3'b011;
   localparam logic [2:0] SEL_J2  = 3'b100;
   localparam logic [2:0] SEL_U   = 3'b101;
   localparam logic [2:0] SEL_S   = 3'b111;

   localparam logic [XLEN-1:0] NOP_WORD  = XLEN'(32'h0000_0013);
   localparam logic [XLEN-1:0] ADDR_STEP = XLEN'(4);
   localparam logic [XLEN-1:0] ADDR_MASK = ~XLEN'(3);
   localparam logic [CNTW-1:0] CNT_MAX   = {CNTW{1'b1}};

   typedef struct packed {
      logic [2:0]      sel;
      logic [6:0]      opcode;
      logic [4:0]      rd;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [2:0]      funct3;
      logic [6:0]      funct7;
      logic [XLEN-1:0] imm;
   } req_t;

   logic            run;
   logic            s1_valid;
   req_t            s1_req;
   logic            s1_adv;
   logic            accept;
   logic            deliver;
   logic [XLEN-1:0] enc_word_c;
   logic            enc_err_c;
   logic            fit12_c;
   logic            fit13_c;
   logic            fit21_c;

   assign s1_adv   = !out_valid || out_ready;
   assign in_ready = run && (!s1_valid || s1_adv);
   assign accept   = in_valid && in_ready;
   assign deliver  = out_valid && out_ready;

   // Holds in_ready low until the first clock edge after reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) run <= 1'b0;
      else        run <= 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_req   <= '0;
      end else begin
         if (accept)      s1_valid <= 1'b1;
         else if (s1_adv) s1_valid <= 1'b0;
         if (accept) s1_req <= '{imm_sel, opcode, rd, rs1, rs2, funct3, funct7, imm};
      end
   end

   // Immediate must equal the sign-extension of its low field.
   always_comb begin
      fit12_c = (s1_req.imm[XLEN-1:11] == {(XLEN-11){s1_req.imm[11]}});
      fit13_c = (s1_req.imm[XLEN-1:12] == {(XLEN-12){s1_req.imm[12]}});
      fit21_c = (s1_req.imm[XLEN-1:20] == {(XLEN-20){s1_req.imm[20]}});
   end

   always_comb begin
      enc_word_c = NOP_WORD;
      enc_err_c  = 1'b1;
      case (s1_req.sel)
         SEL_R: begin
            enc_word_c = {s1_req.funct7, s1_req.rs2, s1_req.rs1, s1_req.funct3,
                          s1_req.rd, s1_req.opcode};
            enc_err_c  = 1'b0;
         end
         SEL_I, SEL_J2: begin
            enc_word_c = {s1_req.imm[11:0], s1_req.rs1, s1_req.funct3,
                          s1_req.rd, s1_req.opcode};
            enc_err_c  = !fit12_c;
         end
         SEL_S: begin
            enc_word_c = {s1_req.imm[11:5], s1_req.rs2, s1_req.rs1, s1_req.funct3,
                          s1_req.imm[4:0], s1_req.opcode};
            enc_err_c  = !fit12_c;
         end
         SEL_B: begin
            enc_word_c = {s1_req.imm[12], s1_req.imm[10:5], s1_req.rs2, s1_req.rs1,
                          s1_req.funct3, s1_req.imm[4:1], s1_req.imm[11], s1_req.opcode};
            enc_err_c  = s1_req.imm[0] || !fit13_c;
         end
         SEL_U: begin
            enc_word_c = {s1_req.imm[31:12], s1_req.rd, s1_req.opcode};
            enc_err_c  = (s1_req.imm[11:0] != 12'd0);
         end
         SEL_J1: begin
            enc_word_c = {s1_req.imm[20], s1_req.imm[10:1], s1_req.imm[11],
                          s1_req.imm[19:12], s1_req.rd, s1_req.opcode};
            enc_err_c  = s1_req.imm[0] || !fit21_c;
         end
         default: begin
            enc_word_c = NOP_WORD;
            enc_err_c  = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         instr     <= '0;
         out_err   <= 1'b0;
      end else if (s1_adv) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            instr   <= enc_word_c;
            out_err <= enc_err_c;
         end
      end
   end

   // Address of the next undelivered word; a reload overrides the delivery step.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         out_addr <= '0;
      else if (addr_load) out_addr <= addr_base & ADDR_MASK;
      else if (deliver)   out_addr <= out_addr + ADDR_STEP;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                     err_cnt <= '0;
      else if (deliver && out_err && err_cnt != CNT_MAX) err_cnt <= err_cnt + CNTW'(1);
   end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed and random stimulus for instr_encoder with a queue scoreboard checked
// on every delivered word, plus round-trip decoding of error-free words.
module tb_instr_encoder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready;
   logic [2:0]  imm_sel;
   logic [6:0]  opcode;
   logic [4:0]  rd, rs1, rs2;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [31:0] imm;
   logic        out_valid, out_ready;
   logic [31:0] instr, out_addr;
   logic        out_err;
   logic [7:0]  err_cnt;
   logic        addr_load;
   logic [31:0] addr_base;

   instr_encoder dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .imm_sel(imm_sel), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
      .funct3(funct3), .funct7(funct7), .imm(imm), .out_valid(out_valid),
      .out_ready(out_ready), .instr(instr), .out_addr(out_addr), .out_err(out_err),
      .err_cnt(err_cnt), .addr_load(addr_load), .addr_base(addr_base)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] instr;
      logic        err;
      logic [31:0] addr;
      logic [7:0]  ecnt;
      logic [2:0]  sel;
      logic [31:0] imm;
   } exp_t;

   exp_t        sb[$];
   int          n_cmp = 0;
   int          n_fail = 0;
   int          n_err = 0;
   logic [31:0] nxt_addr = 32'd0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference encoder with range limits expressed as signed bounds.
   task automatic model(input logic [2:0] sel, input logic [6:0] op, input logic [4:0] d,
                        input logic [4:0] a, input logic [4:0] b, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] im,
                        output logic [31:0] w, output logic e);
      int s;
      s = $signed(im);
      case (sel)
         3'b000: begin w = {f7, b, a, f3, d, op}; e = 1'b0; end
         3'b001, 3'b100: begin
            w = {im[11:0], a, f3, d, op};
            e = !(s >= -2048 && s <= 2047);
         end
         3'b111: begin
            w = {im[11:5], b, a, f3, im[4:0], op};
            e = !(s >= -2048 && s <= 2047);
         end
         3'b010: begin
            w = {im[12], im[10:5], b, a, f3, im[4:1], im[11], op};
            e = im[0] || !(s >= -4096 && s <= 4095);
         end
         3'b101: begin w = {im[31:12], d, op}; e = (im[11:0] != 12'd0); end
         3'b011: begin
            w = {im[20], im[10:1], im[11], im[19:12], d, op};
            e = im[0] || !(s >= -1048576 && s <= 1048575);
         end
         default: begin w = 32'h0000_0013; e = 1'b1; end
      endcase
   endtask

   function automatic logic [31:0] dec(input logic [2:0] sel, input logic [31:0] w);
      logic [12:0] b13;
      logic [20:0] j21;
      b13 = {w[31], w[7], w[30:25], w[11:8], 1'b0};
      j21 = {w[31], w[19:12], w[20], w[30:21], 1'b0};
      case (sel)
         3'b001, 3'b100: dec = {{20{w[31]}}, w[31:20]};
         3'b111:         dec = {{20{w[31]}}, w[31:25], w[11:7]};
         3'b010:         dec = {{19{b13[12]}}, b13};
         3'b101:         dec = {w[31:12], 12'd0};
         3'b011:         dec = {{11{j21[20]}}, j21};
         default:        dec = 32'd0;
      endcase
   endfunction

   task automatic drive(input logic [2:0] sel, input logic [6:0] op, input logic [4:0] d,
                        input logic [4:0] a, input logic [4:0] b, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] im);
      imm_sel = sel; opcode = op; rd = d; rs1 = a; rs2 = b;
      funct3 = f3; funct7 = f7; imm = im; in_valid = 1'b1;
   endtask

   // Holds the request until accepted; pushes the expectation at the accepting edge.
   task automatic send(input logic [2:0] sel, input logic [6:0] op, input logic [4:0] d,
                       input logic [4:0] a, input logic [4:0] b, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] im, input bit bp);
      logic [31:0] w;
      logic        e;
      exp_t        x;
      bit          done;
      done = 1'b0;
      model(sel, op, d, a, b, f3, f7, im, w, e);
      drive(sel, op, d, a, b, f3, f7, im);
      for (int c = 0; c < 200 && !done; c++) begin
         if (bp) out_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         if (in_ready) begin
            x.instr = w; x.err = e; x.addr = nxt_addr;
            x.ecnt = (n_err > 255) ? 8'd255 : 8'(n_err);
            x.sel = sel; x.imm = im;
            sb.push_back(x);
            nxt_addr = nxt_addr + 32'd4;
            if (e) n_err++;
            done = 1'b1;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      if (!done) chk("accept_timeout", {31'd0, in_ready}, 32'd1);
   endtask

   task automatic drain();
      out_ready = 1'b1;
      for (int c = 0; c < 200 && (sb.size() != 0 || out_valid); c++) @(negedge clk);
      chk("drain_empty", 32'(sb.size()), 32'd0);
      @(posedge clk); #1;
   endtask

   always @(negedge clk) begin : mon
      exp_t x;
      if (rst_n && out_valid && out_ready) begin
         if (sb.size() == 0) chk("unexpected_word", {31'd0, out_valid}, 32'd0);
         else begin
            x = sb.pop_front();
            chk("instr", instr, x.instr);
            chk("out_err", {31'd0, out_err}, {31'd0, x.err});
            chk("out_addr", out_addr, x.addr);
            chk("err_cnt", {24'd0, err_cnt}, {24'd0, x.ecnt});
            if (!x.err && x.sel != 3'b000) chk("roundtrip", dec(x.sel, instr), x.imm);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] t, im;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; addr_load = 1'b0; addr_base = '0;
      imm_sel = '0; opcode = '0; rd = '0; rs1 = '0; rs2 = '0; funct3 = '0; funct7 = '0; imm = '0;
      #2;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_instr", instr, 32'd0);
      chk("rst_out_addr", out_addr, 32'd0);
      chk("rst_out_err", {31'd0, out_err}, 32'd0);
      chk("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      chk("in_ready_after_rst", {31'd0, in_ready}, 32'd1);

      // Basic I-type word and two-cycle latency.
      out_ready = 1'b1;
      send(3'b001, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b0);
      chk("lat_n1_valid", {31'd0, out_valid}, 32'd0);
      @(posedge clk); #1;
      chk("lat_n2_valid", {31'd0, out_valid}, 32'd1);
      chk("i_instr", instr, 32'h0050_0093);
      drain();

      send(3'b010, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFC, 1'b0);
      drain();
      chk("b_instr", instr, 32'hFE20_8EE3);
      chk("b_err", {31'd0, out_err}, 32'd0);

      send(3'b001, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 1'b0);
      drain();
      chk("i2048_field", {20'd0, instr[31:20]}, 32'h800);
      chk("i2048_cnt", {24'd0, err_cnt}, 32'd1);
      send(3'b010, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3, 1'b0);
      drain();
      chk("b3_cnt", {24'd0, err_cnt}, 32'd2);

      // Reset with two words in flight.
      out_ready = 1'b0;
      send(3'b000, 7'h33, 5'd3, 5'd4, 5'd5, 3'd0, 7'h20, 32'd0, 1'b0);
      send(3'b001, 7'h13, 5'd6, 5'd7, 5'd0, 3'd1, 7'd0, 32'd9999, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("midrst_err_cnt", {24'd0, err_cnt}, 32'd0);
      chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("midrst_addr", out_addr, 32'd0);
      sb.delete(); nxt_addr = 32'd0; n_err = 0;
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b1;
      send(3'b101, 7'h37, 5'd8, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 1'b0);
      drain();

      // Backpressure: third request stalls until the output drains.
      rst_n = 1'b0; #1;
      sb.delete(); nxt_addr = 32'd0; n_err = 0;
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      send(3'b111, 7'h23, 5'd0, 5'd2, 5'd3, 3'd2, 7'd0, 32'hFFFF_F800, 1'b0);
      send(3'b011, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h000F_FFFE, 1'b0);
      drive(3'b100, 7'h67, 5'd1, 5'd5, 5'd0, 3'd0, 7'd0, 32'd12);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      send(3'b100, 7'h67, 5'd1, 5'd5, 5'd0, 3'd0, 7'd0, 32'd12, 1'b0);
      drain();

      // Address reload coinciding with a delivery, then wrap to zero.
      out_ready = 1'b0;
      send(3'b000, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0, 1'b0);
      @(posedge clk); #1;
      chk("load_pre_valid", {31'd0, out_valid}, 32'd1);
      addr_load = 1'b1; addr_base = 32'hFFFF_FFFF; out_ready = 1'b1;
      @(posedge clk); #1;
      addr_load = 1'b0; addr_base = 32'd0;
      nxt_addr = 32'hFFFF_FFFC;
      send(3'b001, 7'h13, 5'd2, 5'd2, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 1'b0);
      send(3'b001, 7'h13, 5'd3, 5'd3, 5'd0, 3'd0, 7'd0, 32'd2047, 1'b0);
      drain();
      chk("addr_after_wrap", out_addr, 32'd4);

      // Random formats and immediates under random backpressure.
      for (int i = 0; i < 60; i++) begin
         t = $urandom;
         case ($urandom_range(0, 3))
            0: im = $urandom;
            1: im = {{20{t[11]}}, t[11:0]};
            2: im = {{11{t[20]}}, t[20:1], 1'b0};
            default: im = {t[31:12], 12'd0};
         endcase
         send(3'($urandom_range(0, 7)), 7'($urandom), 5'($urandom), 5'($urandom),
              5'($urandom), 3'($urandom), 7'($urandom), im, 1'b1);
      end
      drain();

      // Error counter saturation.
      out_ready = 1'b1;
      for (int i = 0; i < 260; i++)
         send(3'b110, 7'h33, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0, 1'b0);
      drain();
      chk("err_cnt_sat", {24'd0, err_cnt}, 32'd255);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 in_valid  input  1  request fields below are valid.
REQ-004 in_ready  output  1  encoder accepts request this cycle.
REQ-005 imm_sel  input  3  format: 000 R, 001 I, 010 B, 011 J1 (JAL), 100 J2 (JALR, I-layout), 101 U, 111 S, 110 reserved.
REQ-006 opcode  input  7; rd, rs1, rs2  input  5 each; funct3  input  3; funct7  input  7  instruction fields.
REQ-007 imm  input  32  full sign-extended immediate value to encode.
REQ-008 out_valid  output  1; out_ready  input  1  output handshake.
REQ-009 instr  output  32  encoded instruction word.
REQ-010 out_addr  output  32  word address assigned to instr.
REQ-011 out_err  output  1  immediate range/format error for the current output word.
REQ-012 err_cnt  output  8  saturating count of errored words delivered.
REQ-013 addr_load  input  1; addr_base  input  32  reload of the address counter.

Function
REQ-014 Two-stage pipeline. S1 registers the request. S2 holds the encoded word, out_err and out_addr.
REQ-015 A request is accepted when in_valid && in_ready. A word is delivered when out_valid && out_ready.
REQ-016 in_ready = !S1_valid || S1 can advance. S1 advances when !S2_valid || out_ready. Full throughput is one word per cycle.
REQ-017 Latency: a word accepted in cycle N shows out_valid in cycle N+2 when there is no backpressure.
REQ-018 While out_valid=1 && out_ready=0, instr, out_addr and out_err are held stable.
REQ-019 No request is dropped or duplicated, and output order equals acceptance order.
REQ-020 Encodings:
  - R: {funct7,rs2,rs1,funct3,rd,opcode}
  - I/J2: {imm[11:0],rs1,funct3,rd,opcode}
  - S: {imm[11:5],rs2,rs1,funct3,imm[4:0],opcode}
  - B: {imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],opcode}
  - U: {imm[31:12],rd,opcode}
  - J1: {imm[20],imm[10:1],imm[11],imm[19:12],rd,opcode}
REQ-021 Range rules; a violation sets out_err=1:
  - I/J2/S: imm equals the sign-extension of imm[11:0].
  - B: imm[0]=0 and imm fits 13-bit signed.
  - J1: imm[0]=0 and imm fits 21-bit signed.
  - U: imm[11:0]=0.
  - R: imm is ignored and never causes an error.
REQ-022 On a range error the word is still emitted, with the truncated bit fields per REQ-020.
REQ-023 imm_sel=110 sets out_err=1 and emits instr=32'h00000013.
REQ-024 Round-trip property: for any error-free word, decoding instr with the same imm_sel recovers imm exactly.
REQ-025 out_addr of the first word after reset is 0. The counter advances by 4 on each delivery.
REQ-026 The counter wraps from 32'hFFFFFFFC to 0.
REQ-027 addr_load=1 sets the address of the next undelivered word to addr_base, with addr_base[1:0] forced to 0.
REQ-028 When addr_load=1 coincides with a delivery, the load wins.
REQ-029 err_cnt increments on each delivered word with out_err=1 and saturates at 255.

Reset
REQ-030 When rst_n=0, the following clear immediately, independent of clk: both stage valids, out_valid=0, out_addr=0, out_err=0, err_cnt=0, instr=0.
REQ-031 During reset in_ready=0. It rises in the first cycle after rst_n deasserts.
REQ-032 Reset mid-operation discards all in-flight requests. No partial word is ever emitted.

Verification
REQ-033 I-type input (opcode=7'h13, rd=1, rs1=0, funct3=0, imm=5), out_ready=1 -> instr=32'h00500093, out_valid exactly 2 cycles after accept, out_addr=0, out_err=0.
REQ-034 B-type input (opcode=7'h63, rs1=1, rs2=2, funct3=0, imm=32'hFFFFFFFC) -> instr=32'hFE208EE3, out_err=0.
REQ-035 I-type input with imm=2048 -> out_err=1, instr[31:20]=12'h800, err_cnt=1. Next: B-type imm=3 -> out_err=1, err_cnt=2.
REQ-036 Three back-to-back requests with out_ready=0 for 4 cycles -> in_ready drops after 2 accepts. Then out_ready=1 -> all 3 words delivered in order at out_addr 0, 4, 8.
REQ-037 addr_load=1 with addr_base=32'hFFFFFFFC asserted in the same cycle as a delivery -> next word at 32'hFFFFFFFC, the following word at 0.
REQ-038 rst_n pulsed low with 2 words in flight -> out_valid=0 and err_cnt=0 immediately. After release, the next request is delivered at out_addr=0.
